// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer.
package debounce_pkg;

   // Debouncer FSM states
   typedef enum logic [1:0] {
      ST_LO  = 2'd0,
      CHK_HI = 2'd1,
      ST_HI  = 2'd2,
      CHK_LO = 2'd3
   } deb_state_t;

   localparam int unsigned DEB_STABLE_CYCLES_DEF = 4;
   localparam int unsigned DEB_CNT_W_DEF         = 8;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser, synchronous active-high reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/input_debouncer.sv
// Counter-based debouncer producing a clean level plus rise/fall pulses.
// Optional feature: define DEBOUNCE_SYNC_EN to insert a two-flop synchroniser
// on din; without it din must already be synchronous to clk.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
   parameter int unsigned CNT_W         = DEB_CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             din_s;
   deb_state_t       state;
   logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCE_SYNC_EN
   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (din_s)
   );
`else
   assign din_s = din;
`endif

   // Qualification FSM with counter; all outputs registered alongside state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_LO;
         cnt   <= '0;
         q     <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            ST_LO: begin
               if (din_s) begin
                  state <= CHK_HI;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            CHK_HI: begin
               if (!din_s) begin
                  state <= ST_LO;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_MAX) begin
                  state <= ST_HI;
                  cnt   <= '0;
                  q     <= 1'b1;
                  rise  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_HI: begin
               if (!din_s) begin
                  state <= CHK_LO;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            CHK_LO: begin
               if (din_s) begin
                  state <= ST_HI;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_MAX) begin
                  state <= ST_LO;
                  cnt   <= '0;
                  q     <= 1'b0;
                  fall  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_LO;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (default params plus a STABLE_CYCLES=1 instance).
module tb_input_debouncer;

   localparam int SC = 4;
`ifdef DEBOUNCE_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif
   localparam int LAT  = SC + 1 + SYNC;
   localparam int LAT1 = 2 + SYNC;

   logic clk = 1'b0;
   logic rst, din, din1;
   logic q, rise, fall, busy;
   logic q1, rise1, fall1, busy1;

   always #5 clk = ~clk;

   input_debouncer dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .q    (q),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   input_debouncer #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
      .clk  (clk),
      .rst  (rst),
      .din  (din1),
      .q    (q1),
      .rise (rise1),
      .fall (fall1),
      .busy (busy1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_rise;
      int cycle;
   } ev_t;

   ev_t exp_q[$];
   int  errors = 0;
   int  checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
      end
   endtask

   // Monitor: every pulse from the main DUT is matched against the scoreboard
   always @(negedge clk) begin
      if (rise === 1'b1 || fall === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, rise, fall}, 32'd0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("pulse_rise",  32'(rise), 32'(e.is_rise));
            chk("pulse_fall",  32'(fall), 32'(!e.is_rise));
            chk("pulse_cycle", 32'(cyc),  32'(e.cycle));
            chk("pulse_q",     32'(q),    32'(e.is_rise));
         end
      end
   end

   task automatic push(input bit r, input int c);
      ev_t e;
      e.is_rise = r;
      e.cycle   = c;
      exp_q.push_back(e);
   endtask

   // Step din at a negedge and check busy across the qualification window
   task automatic step(input bit lvl);
      int c;
      din = lvl;
      c = cyc;
      push(lvl, c + LAT);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk("step_busy", 32'(busy), 32'(k > SYNC && k < LAT));
      end
      chk("step_q", 32'(q), 32'(lvl));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int c;
      rst  = 1'b1;
      din  = 1'b1;
      din1 = 1'b1;

      // Reset held two edges with din high
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst_q",    32'(q),    32'd0);
         chk("rst_rise", 32'(rise), 32'd0);
         chk("rst_fall", 32'(fall), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      rst = 1'b0;
      c = cyc;
      push(1'b1, c + LAT);
      for (int k = 1; k <= LAT1; k++) begin
         @(negedge clk);
         chk("sc1_q_rise", 32'(q1), 32'(k == LAT1));
      end
      chk("sc1_rise_pulse", 32'(rise1), 32'd1);
      repeat (LAT - LAT1 + 2) @(negedge clk);
      chk("post_rst_q",    32'(q),    32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // STABLE_CYCLES=1 instance: 1->0 from ST_HI together with main clean fall
      din  = 1'b0;
      din1 = 1'b0;
      c = cyc;
      push(1'b0, c + LAT);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk("fall_busy", 32'(busy), 32'(k > SYNC && k < LAT));
         if (k == LAT1) begin
            chk("sc1_fall_pulse", 32'(fall1), 32'd1);
            chk("sc1_q_fall",     32'(q1),    32'd0);
         end
      end
      repeat (2) @(negedge clk);

      // Clean rise and fall
      step(1'b1);
      step(1'b0);

      // Glitch of 3 samples: no change, busy drops on the edge after it ends
      din = 1'b1;
      for (int k = 1; k <= SYNC + 6; k++) begin
         @(negedge clk);
         chk("glitch_busy", 32'(busy), 32'(k > SYNC && k <= SYNC + 3));
         chk("glitch_q",    32'(q),    32'd0);
         if (k == 3) din = 1'b0;
      end

      // Bounce then settle high
      din = 1'b1;
      @(negedge clk);
      din = 1'b0;
      @(negedge clk);
      din = 1'b1;
      c = cyc;
      push(1'b1, c + LAT);
      repeat (LAT + 4) @(negedge clk);
      chk("bounce_q", 32'(q), 32'd1);
      step(1'b0);

      // Reset at the 5th edge of a qualification abandons it
      din = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_q",    32'(q),    32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rise", 32'(rise), 32'd0);
      rst = 1'b0;
      c = cyc;
      push(1'b1, c + LAT);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk("restart_busy", 32'(busy), 32'(k > SYNC && k < LAT));
      end
      chk("restart_q", 32'(q), 32'd1);
      repeat (2) @(negedge clk);

      step(1'b0);

      chk("pending_events", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
